// File: rtl/axi_line_fill_pkg.sv
// axi_fill_pkg: shared definitions for the axi_line_fill cache-line refill engine.
//   fill_state_t      - refill FSM states (IDLE, ADDR, DATA, RESP)
//   AXI_BURST_*       - AXI4 AxBURST encodings used by the engine
//   AXI_RESP_OKAY     - AXI4 xRESP "OKAY" encoding
//   LINE_BYTES        - line size in bytes for the default geometry (16 x 64-bit)
//   OFFSET_BITS       - byte-offset bits within a line for the default geometry
//   fill_line_bytes() / fill_offset_bits() derive the same values for any geometry.
package axi_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } fill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int fill_line_bytes(input int beats, input int data_width);
    return beats * data_width / 8;
  endfunction

  function automatic int fill_offset_bits(input int beats, input int data_width);
    return $clog2(beats * data_width / 8);
  endfunction

  localparam int LINE_BYTES  = fill_line_bytes(16, 64);
  localparam int OFFSET_BITS = fill_offset_bits(16, 64);

endpackage

// File: rtl/axi_line_fill_if.sv
// axi_line_fill_if: AXI4 read-address (AR) and read-data (R) channels.
//   master modport - the refill engine (drives AR, accepts R)
//   slave  modport - the memory side (accepts AR, drives R)
// Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH must match the engine's.
interface axi_line_fill_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) ();

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi_line_fill_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req       in  NREQ  request vector
//   ptr       in  IW    highest-priority index this cycle
//   grant     out NREQ  one-hot grant (0 when no request)
//   grant_idx out IW    binary index of the granted requester
// The winner is the first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_line_fill.sv
// axi_line_fill: read-only cache-line refill engine (one transaction outstanding).
// Ports:
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous active-low reset
//   req_valid   in   NREQ             refill requests (0 = data cache, 1 = instruction cache)
//   req_addr    in   NREQ*ADDR_WIDTH  request byte addresses, requester i in slice i
//   req_ready   out  NREQ             one-hot accept pulse (combinational, IDLE only)
//   resp_valid  out  NREQ             one-hot line-ready indication
//   resp_ready  in   NREQ             response accept
//   resp_data   out  BEATS*DATA_WIDTH assembled line, beat k at [k*DATA_WIDTH +: DATA_WIDTH]
//   resp_err    out  1                any beat errored or rlast was misplaced
//   m_axi       axi_line_fill_if.master  AXI4 AR/R channels
// Optional: define AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN for WRAP bursts that start at
// the requested beat; otherwise an aligned INCR burst is issued.
module axi_line_fill
  import axi_fill_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 16,
  parameter int NREQ       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0]  req_addr,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             resp_valid,
  input  logic [NREQ-1:0]             resp_ready,
  output logic [BEATS*DATA_WIDTH-1:0] resp_data,
  output logic                        resp_err,
  axi_line_fill_if.master             m_axi
);

  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW        = $clog2(BEATS);
  localparam int LINE_SZ   = fill_line_bytes(BEATS, DATA_WIDTH);
  localparam int OFF_BITS  = fill_offset_bits(BEATS, DATA_WIDTH);
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(DATA_WIDTH / 8 - 1));
  localparam logic [1:0]            BURST     = AXI_BURST_WRAP;
`else
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(LINE_SZ - 1));
  localparam logic [1:0]            BURST     = AXI_BURST_INCR;
`endif

  fill_state_t           state_reg;
  logic [IW-1:0]         grant_reg;
  logic [IW-1:0]         rr_ptr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [BW-1:0]         beat_cnt_reg;
  logic                  err_reg;
  logic                  discard_reg;
  logic [DATA_WIDTH-1:0] line_reg [BEATS];
`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
  logic [BW-1:0]         rcv_cnt_reg;
`endif

  logic [NREQ-1:0]       win_onehot;
  logic [IW-1:0]         win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] req_addr_arr [NREQ];
  logic [BW-1:0]         start_beat;
  logic [BW-1:0]         beat_cnt_next;
  logic [IW-1:0]         rr_ptr_next;
  logic                  last_pos;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (win_onehot),
    .grant_idx (win_idx)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign resp_valid[gi]   = (state_reg == RESP) && (grant_reg == IW'(gi));
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] = line_reg[gi];
  end

  assign win_addr      = req_addr_arr[win_idx];
  assign beat_cnt_next = (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + 1'b1;
  assign rr_ptr_next   = (grant_reg == IW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;

`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
  // The line index wraps, so the end of the burst is found by counting beats received.
  assign start_beat = win_addr[OFF_BITS-1:BYTE_BITS];
  assign last_pos   = (rcv_cnt_reg == LAST_BEAT);
`else
  assign start_beat = '0;
  assign last_pos   = (beat_cnt_reg == LAST_BEAT);
`endif

  // Accept is gated by reset so nothing looks accepted during a reset cycle.
  assign req_ready = (state_reg == IDLE && reset) ? win_onehot : '0;
  assign resp_err  = err_reg;

  assign m_axi.m_axi_arid    = ID_WIDTH'(grant_reg);
  assign m_axi.m_axi_araddr  = addr_reg & ADDR_MASK;
  assign m_axi.m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi.m_axi_arsize  = 3'(BYTE_BITS);
  assign m_axi.m_axi_arburst = BURST;
  assign m_axi.m_axi_arvalid = (state_reg == ADDR);
  assign m_axi.m_axi_rready  = (state_reg == DATA);

  // rid is ignored: only one burst is ever in flight.
  logic unused_rid;
  assign unused_rid = &{1'b0, m_axi.m_axi_rid};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      addr_reg     <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
      discard_reg  <= 1'b0;
`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
      rcv_cnt_reg  <= '0;
`endif
      for (int i = 0; i < BEATS; i++) line_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            grant_reg    <= win_idx;
            addr_reg     <= win_addr;
            beat_cnt_reg <= start_beat;
`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
            rcv_cnt_reg  <= '0;
`endif
            state_reg    <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi.m_axi_arready) state_reg <= DATA;
        end
        DATA: begin
          if (m_axi.m_axi_rvalid) begin
            if (discard_reg) begin
              // Overlong burst: swallow beats until the slave finally ends it.
              if (m_axi.m_axi_rlast) begin
                discard_reg <= 1'b0;
                state_reg   <= RESP;
              end
            end else begin
              line_reg[beat_cnt_reg] <= m_axi.m_axi_rdata;
              beat_cnt_reg           <= beat_cnt_next;
`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
              rcv_cnt_reg            <= rcv_cnt_reg + 1'b1;
`endif
              if (m_axi.m_axi_rresp != AXI_RESP_OKAY) err_reg <= 1'b1;
              if (last_pos) begin
                if (m_axi.m_axi_rlast) begin
                  state_reg <= RESP;
                end else begin
                  err_reg     <= 1'b1;
                  discard_reg <= 1'b1;
                end
              end else if (m_axi.m_axi_rlast) begin
                err_reg   <= 1'b1;
                state_reg <= RESP;
              end
            end
          end
        end
        RESP: begin
          if (resp_ready[grant_reg]) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= rr_ptr_next;
            err_reg      <= 1'b0;
            beat_cnt_reg <= '0;
`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
            rcv_cnt_reg  <= '0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_fill.sv
// tb_axi_line_fill: table-driven bench for axi_line_fill. The bench plays both the
// requesters and the AXI memory, checks AR fields, grant order, line contents,
// error flag and resp_valid timing; hand sequences cover reset state and reset mid-burst.
module tb_axi_line_fill;

  localparam int BEATS = 16;
  localparam int NREQ  = 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*64-1:0]   req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [BEATS*64-1:0]  resp_data;
  logic                 resp_err;

  axi_line_fill_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) axi ();

  axi_line_fill #(
    .ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .BEATS(BEATS), .NREQ(NREQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .m_axi      (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [63:0] a0;
    logic [63:0] a1;
    int          ar_delay;
    int          gap;
    int          err_beat;
    int          rlast_beat;
    int          resp_delay;
    logic [1:0]  exp_grant;
    logic [63:0] araddr_incr;
    logic [63:0] araddr_wrap;
    logic        exp_err;
    logic [31:0] seed;
  } fill_vec_t;

  fill_vec_t   vecs [12];
  fill_vec_t   hv;
  logic [63:0] model [BEATS];
  int          errors;
  int          checks;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_line();
    int bad;
    bad = -1;
    for (int b = 0; b < BEATS; b++)
      if (bad < 0 && resp_data[b*64 +: 64] !== model[b]) bad = b;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL line beat %0d: got %h expected %h", bad, resp_data[bad*64 +: 64], model[bad]);
    end
  endtask

  // One full refill (or, with abort_at >= 0, a refill cut short by reset after that beat).
  task automatic run_fill(input fill_vec_t v, input int idx, input int abort_at);
    logic [63:0] req_a;
    logic [63:0] exp_araddr;
    logic [1:0]  exp_burst;
    logic [63:0] d;
    int          start;
    int          nbeats;
    req_a = v.exp_grant[1] ? v.a1 : v.a0;
`ifdef AXI_LINE_FILL_CRITICAL_WORD_FIRST_EN
    exp_araddr = v.araddr_wrap;
    exp_burst  = 2'b10;
    start      = int'(req_a[6:3]);
`else
    exp_araddr = v.araddr_incr;
    exp_burst  = 2'b01;
    start      = 0;
`endif
    nbeats = (abort_at >= 0) ? abort_at + 1 : v.rlast_beat + 1;

    req_valid = v.req;
    req_addr  = {v.a1, v.a0};
    #1;
    chk("req_ready_accept", 64'(req_ready), 64'(v.exp_grant));
    tick();
    req_valid = v.req & ~v.exp_grant;
    #1;
    chk("req_ready_busy", 64'(req_ready), 64'd0);

    for (int dly = 0; dly <= v.ar_delay; dly++) begin
      chk("arvalid", 64'(axi.m_axi_arvalid), 64'd1);
      chk("araddr", axi.m_axi_araddr, exp_araddr);
      chk("arlen", 64'(axi.m_axi_arlen), 64'd15);
      chk("arsize", 64'(axi.m_axi_arsize), 64'd3);
      chk("arburst", 64'(axi.m_axi_arburst), 64'(exp_burst));
      chk("arid", 64'(axi.m_axi_arid), 64'(v.exp_grant[1]));
      axi.m_axi_arready = (dly == v.ar_delay);
      tick();
    end
    axi.m_axi_arready = 1'b0;
    chk("arvalid_drop", 64'(axi.m_axi_arvalid), 64'd0);
    chk("rready", 64'(axi.m_axi_rready), 64'd1);

    for (int k = 0; k < nbeats; k++) begin
      if (v.gap != 0 && (k % 2) == 1) tick();
      d = {v.seed, 32'(k)};
      axi.m_axi_rvalid = 1'b1;
      axi.m_axi_rdata  = d;
      axi.m_axi_rresp  = (k == v.err_beat) ? 2'b10 : 2'b00;
      axi.m_axi_rlast  = (abort_at < 0) && (k == v.rlast_beat);
      axi.m_axi_rid    = 13'(v.exp_grant[1]);
      if (k < BEATS) model[(start + k) % BEATS] = d;
      if (k == nbeats - 1 && abort_at < 0)
        chk("resp_valid_early", 64'(resp_valid), 64'd0);
      tick();
      axi.m_axi_rvalid = 1'b0;
      axi.m_axi_rlast  = 1'b0;
      axi.m_axi_rresp  = 2'b00;
    end

    if (abort_at >= 0) begin
      req_valid = '0;
      reset     = 1'b0;
      tick();
      for (int b = 0; b < BEATS; b++) model[b] = '0;
      chk("rst_rready", 64'(axi.m_axi_rready), 64'd0);
      chk("rst_arvalid", 64'(axi.m_axi_arvalid), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", 64'(|resp_data), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      reset = 1'b1;
      tick();
      $display("txn %0d: aborted by reset after beat %0d", idx, abort_at);
      return;
    end

    chk("resp_valid", 64'(resp_valid), 64'(v.exp_grant));
    chk("resp_err", 64'(resp_err), 64'(v.exp_err));
    check_line();
    for (int r = 0; r < v.resp_delay; r++) begin
      tick();
      chk("resp_valid_hold", 64'(resp_valid), 64'(v.exp_grant));
      chk("resp_err_hold", 64'(resp_err), 64'(v.exp_err));
    end
    resp_ready = v.exp_grant;
    tick();
    resp_ready = '0;
    chk("resp_valid_drop", 64'(resp_valid), 64'd0);
    $display("txn %0d: req=%b grant=%b araddr=%h beats=%0d err=%b", idx, v.req, v.exp_grant,
             exp_araddr, nbeats, v.exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int b = 0; b < BEATS; b++) model[b] = '0;
    reset             = 1'b0;
    req_valid         = '0;
    req_addr          = '0;
    resp_ready        = '0;
    axi.m_axi_arready = 1'b0;
    axi.m_axi_rid     = '0;
    axi.m_axi_rdata   = '0;
    axi.m_axi_rresp   = 2'b00;
    axi.m_axi_rlast   = 1'b0;
    axi.m_axi_rvalid  = 1'b0;

    //         req    a0                      a1                      ard gap errb rl  rdly gnt    araddr INCR             araddr WRAP             err   seed
    vecs[0]  = '{2'b11, 64'h0000_0000_1000_0040, 64'h0000_0000_2000_0088, 0, 0, 99, 15, 0, 2'b01, 64'h0000_0000_1000_0000, 64'h0000_0000_1000_0040, 1'b0, 32'hA000_0000};
    vecs[1]  = '{2'b10, 64'h0000_0000_1000_0040, 64'h0000_0000_2000_0088, 0, 0, 99, 15, 0, 2'b10, 64'h0000_0000_2000_0080, 64'h0000_0000_2000_0088, 1'b0, 32'hA000_0001};
    vecs[2]  = '{2'b11, 64'h0000_0000_3000_00F8, 64'h0000_0000_2000_0088, 0, 0, 99, 15, 0, 2'b01, 64'h0000_0000_3000_0080, 64'h0000_0000_3000_00F8, 1'b0, 32'hA000_0002};
    vecs[3]  = '{2'b01, 64'h0000_0000_8000_0048, 64'h0,                   0, 0, 99, 15, 0, 2'b01, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0048, 1'b0, 32'h0000_0000};
    vecs[4]  = '{2'b10, 64'h0,                   64'h0000_1234_5678_9ABC, 0, 0, 99, 15, 0, 2'b10, 64'h0000_1234_5678_9A80, 64'h0000_1234_5678_9AB8, 1'b0, 32'hB000_0004};
    vecs[5]  = '{2'b01, 64'h0000_0000_4000_0100, 64'h0,                   5, 1, 99, 15, 3, 2'b01, 64'h0000_0000_4000_0100, 64'h0000_0000_4000_0100, 1'b0, 32'hB000_0005};
    vecs[6]  = '{2'b10, 64'h0,                   64'h0000_0000_2000_07F8, 0, 0,  7, 15, 0, 2'b10, 64'h0000_0000_2000_0780, 64'h0000_0000_2000_07F8, 1'b1, 32'hB000_0006};
    vecs[7]  = '{2'b01, 64'h0000_0000_8000_0048, 64'h0,                   0, 0, 99,  9, 0, 2'b01, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0048, 1'b1, 32'hB000_0007};
    vecs[8]  = '{2'b10, 64'h0,                   64'hFFFF_FFFF_FFFF_FFC0, 0, 0, 99, 18, 1, 2'b10, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 32'hB000_0008};
    vecs[9]  = '{2'b01, 64'h0,                   64'h0,                   0, 0, 99, 15, 0, 2'b01, 64'h0,                   64'h0,                   1'b0, 32'hB000_0009};
    vecs[10] = '{2'b11, 64'h0000_0000_5000_0000, 64'h0000_0000_6000_0208, 0, 0, 99, 15, 0, 2'b10, 64'h0000_0000_6000_0200, 64'h0000_0000_6000_0208, 1'b0, 32'hB000_000A};
    vecs[11] = '{2'b01, 64'h0000_0000_0000_0400, 64'h0,                   1, 0, 99, 15, 0, 2'b01, 64'h0000_0000_0000_0400, 64'h0000_0000_0000_0400, 1'b0, 32'hB000_000B};

    // Reset state, with a request already pending that must not be accepted.
    req_valid = 2'b01;
    req_addr  = {64'h0, 64'h1000};
    tick();
    tick();
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_arvalid", 64'(axi.m_axi_arvalid), 64'd0);
    chk("reset_rready", 64'(axi.m_axi_rready), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_data", 64'(|resp_data), 64'd0);
    chk("reset_resp_err", 64'(resp_err), 64'd0);
    req_valid = '0;
    reset     = 1'b1;
    tick();
    chk("idle_arvalid", 64'(axi.m_axi_arvalid), 64'd0);

    for (int i = 0; i < 12; i++) run_fill(vecs[i], i, -1);

    // Reset after beat 5 while serving requester 1 (pointer = 1), then the pointer
    // must restart at 0 so a double request goes to requester 0.
    hv = '{2'b10, 64'h0, 64'h0000_0000_7000_0010, 0, 0, 99, 15, 0, 2'b10,
           64'h0000_0000_7000_0000, 64'h0000_0000_7000_0010, 1'b0, 32'hC000_0000};
    run_fill(hv, 12, 5);
    hv = '{2'b11, 64'h0000_0000_9000_0040, 64'h0000_0000_9100_0000, 0, 0, 99, 15, 0, 2'b01,
           64'h0000_0000_9000_0000, 64'h0000_0000_9000_0040, 1'b0, 32'hC000_0001};
    run_fill(hv, 13, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
